// File: rtl/fifo_pop_ctrl.sv
// Read stage behind the fifo block: pops words through a one-cycle-latency read port into
// a 2-entry skid buffer and hands them on over valid/ready, counting every pop.
module fifo_pop_ctrl #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  buf_empty,
  input  logic [DATA_WIDTH-1:0] buf_out,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [CNT_WIDTH-1:0]  pop_count,
  output logic                  busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  pend_q;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  pop_count_q;
  logic                  xfer;
  logic [2:0]            occ;

  assign valid_out = (cnt_q != 2'd0);
  assign data_out  = head_q;
  assign xfer      = valid_out & ready_in;

  // Occupancy once this cycle's transfer and the in-flight word are settled; a new read
  // is only issued if that word is guaranteed a slot.
  assign occ   = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, xfer};
  assign rd_en = (state_q == StRun) & ~buf_empty & (occ < 3'd2);

  assign busy      = (state_q != StIdle) | pend_q | (cnt_q != 2'd0);
  assign pop_count = pop_count_q;

  // Skid buffer: head is the oldest word, tail the second one.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({pend_q, xfer})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = buf_out;
        else               tail_d = buf_out;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = buf_out;
        end else begin
          head_d = buf_out;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (enable) state_d = StRun;
      end
      StRun: begin
        if (!enable) state_d = (pend_q || cnt_q != 2'd0) ? StDrain : StIdle;
      end
      StDrain: begin
        if (enable)                           state_d = StRun;
        else if (!pend_q && cnt_q == 2'd0)    state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pend_q      <= 1'b0;
      cnt_q       <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      pop_count_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= rd_en;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (rd_en) pop_count_q <= pop_count_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Scoreboard bench for fifo_pop_ctrl: a behavioural FIFO feeds the DUT, pushed words are
// expected back in order, and a negedge monitor checks every delivered word.
module tb_fifo_pop_ctrl;
  localparam int DW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, enable, buf_empty, ready_in;
  logic          rd_en, valid_out, busy;
  logic [DW-1:0] buf_out = '0;
  logic [DW-1:0] data_out;
  logic [CW-1:0] pop_count;

  always #5 clk = ~clk;

  fifo_pop_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .buf_empty (buf_empty),
    .buf_out   (buf_out),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .pop_count (pop_count),
    .busy      (busy)
  );

  // Behavioural FIFO with one-cycle read latency.
  logic [DW-1:0] mem [0:63];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            rd_pulses = 0;
  assign buf_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      buf_out   <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
      rd_pulses <= rd_pulses + 1;
    end
  end

  int            checks = 0;
  int            errors = 0;
  int            empty_viol = 0;
  int            exp_pops = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_word;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: the handshake seen at negedge is the one that completes at the next posedge.
  always @(negedge clk) begin
    if (rst && valid_out && ready_in) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got %0d expected none", data_out);
      end else begin
        exp_word = exp_q.pop_front();
        if (data_out !== exp_word) begin
          errors++;
          $display("FAIL word_order got %0d expected %0d", data_out, exp_word);
        end
      end
    end
    if (rd_en && buf_empty) empty_viol++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
    exp_q.push_back(w);
    exp_pops++;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_out) && n < max_cyc) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  int first_rd, first_vld, last_rd, last_vld, n_rd, n_vld, r0, r1, r2, hold_bad;

  initial begin
    rst = 1'b0; enable = 1'b1; ready_in = 1'b1;
    // Reset with a non-empty FIFO and enable high.
    push(4'h1); push(4'h2);
    tick(2);
    check("rst_rd_en", rd_en, 0);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_pop_count", pop_count, 0);
    check("rst_busy", busy, 0);
    wr_ptr = rd_ptr; exp_q.delete(); exp_pops = 0;
    enable = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);

    // Stream of three words at full throughput.
    push(4'h1); push(4'h2); push(4'h3);
    enable = 1'b1;
    first_rd = -1; first_vld = -1; n_rd = 0; n_vld = 0; last_rd = 0; last_vld = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rd_en) begin
        if (first_rd < 0) first_rd = k;
        last_rd = k; n_rd++;
      end
      if (valid_out) begin
        if (first_vld < 0) first_vld = k;
        last_vld = k; n_vld++;
      end
    end
    tick(1);
    check("stream_rd_count", n_rd, 3);
    check("stream_rd_contig", last_rd - first_rd, 2);
    check("stream_latency", first_vld - first_rd, 2);
    check("stream_vld_contig", last_vld - first_vld, 2);
    check("stream_pop_count", pop_count, exp_pops % 8);
    check("stream_drained", exp_q.size(), 0);

    // Backpressure: only two words leave the FIFO, head held stable.
    ready_in = 1'b0;
    r0 = rd_pulses;
    for (int i = 0; i < 8; i++) push(DW'(i + 5));
    hold_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (valid_out && data_out !== 4'h5) hold_bad++;
    end
    tick(1);
    check("bp_rd_pulses", rd_pulses - r0, 2);
    check("bp_valid", valid_out, 1);
    check("bp_head", data_out, 5);
    check("bp_hold", hold_bad, 0);
    ready_in = 1'b1;
    wait_drain("bp_drain", 40);
    check("bp_rd_total", rd_pulses - r0, 8);
    check("bp_pop_count", pop_count, exp_pops % 8);

    // Empty FIFO: no reads; then a short burst that runs dry.
    r0 = rd_pulses;
    tick(5);
    check("empty_no_rd", rd_pulses - r0, 0);
    push(4'hA); push(4'hB);
    wait_drain("empty_last_word", 20);
    check("empty_rd_total", rd_pulses - r0, 2);
    check("empty_viol", empty_viol, 0);

    // Disable right after a read: in-flight word still delivered, then idle.
    push(4'hD);
    @(negedge clk);
    check("dis_rd_seen", rd_en, 1);
    tick(1);
    enable = 1'b0;
    for (int k = 0; k < 10 && busy; k++) tick(1);
    check("dis_idle_busy", busy, 0);
    check("dis_delivered", exp_q.size(), 0);
    r0 = rd_pulses;
    for (int i = 0; i < 5; i++) push(DW'(i + 1));
    tick(3);
    check("idle_no_rd", rd_pulses - r0, 0);

    // Re-enable while draining.
    enable = 1'b1; ready_in = 1'b0;
    tick(6);
    check("drain_pre_rd", rd_pulses - r0, 2);
    enable = 1'b0; ready_in = 1'b1;
    tick(1);
    r1 = rd_pulses;
    tick(1);
    r2 = rd_pulses;
    check("drain_no_rd", r2 - r1, 0);
    check("drain_busy", busy, 1);
    enable = 1'b1;
    wait_drain("drain_resume", 40);
    check("drain_rd_total", rd_pulses - r0, 5);
    check("drain_fifo_empty", buf_empty, 1);

    // Reset mid-stream discards everything at once.
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(i + 9));
    tick(5);
    rst = 1'b0;
    #1;
    check("mrst_rd_en", rd_en, 0);
    check("mrst_valid", valid_out, 0);
    check("mrst_data", data_out, 0);
    check("mrst_pop_count", pop_count, 0);
    check("mrst_busy", busy, 0);
    wr_ptr = rd_ptr; exp_q.delete(); exp_pops = 0;
    tick(1);
    rst = 1'b1; ready_in = 1'b1;

    // Nine pops wrap a 3-bit counter to one.
    r0 = rd_pulses;
    for (int i = 0; i < 9; i++) push(DW'(15 - i));
    wait_drain("wrap_drain", 40);
    check("wrap_rd_total", rd_pulses - r0, 9);
    check("wrap_pop_count", pop_count, 1);
    check("final_empty_viol", empty_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
